// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit: forward-select encodings,
// the "operand not used" Tuse value and default field widths.
package hazard_unit_pkg;

    localparam int REG_AW = 5;
    localparam int T_W    = 2;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_E    = 2'b11;

    localparam logic [1:0] TUSE_UNUSED = 2'b11;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority matcher for one operand read: the youngest producer whose
// destination matches the register wins (E, then M, then W). A match on a
// producer that has not produced its value yet returns FWD_NONE rather than
// falling through to an older, stale producer; the stall logic holds the
// consumer in that case.
module hazard_fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] reg_idx,
    input  logic [REG_AW-1:0] e_a3,
    input  logic [REG_AW-1:0] m_a3,
    input  logic [REG_AW-1:0] w_a3,
    input  logic              e_rdy,
    input  logic              m_rdy,
    output logic [1:0]        sel
);

    // Youngest-first destination match, register 0 never forwards
    always_comb begin
        sel = FWD_NONE;
        if (reg_idx != '0) begin
            if (e_a3 == reg_idx)
                sel = e_rdy ? FWD_E : FWD_NONE;
            else if (m_a3 == reg_idx)
                sel = m_rdy ? FWD_M : FWD_NONE;
            else if (w_a3 == reg_idx)
                sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline. Consumes the decoder's
// Tuse/Tnew information for the instruction in D, keeps a shadow copy of
// destination register and remaining Tnew for the E/M/W stages, and drives
// stall plus per-operand forward selects.
// Optional: define HAZARD_PERF_EN to add the 32-bit stall_cnt counter port.
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int T_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [REG_AW-1:0] D_A3,
    input  logic [T_W-1:0]    D_Tuse_rs,
    input  logic [T_W-1:0]    D_Tuse_rt,
    input  logic [T_W-1:0]    D_Tnew,
    output logic              stall,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic              fwd_M_rt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    import hazard_unit_pkg::*;

    // Decrement that floors at zero: a produced value stays produced
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : T_W'(t - 1'b1);
    endfunction

    logic [REG_AW-1:0] e_a3_p0, e_rs_p0, e_rt_p0;
    logic [T_W-1:0]    e_tnew_p0;
    logic [REG_AW-1:0] m_a3_p1, m_rt_p1;
    logic [T_W-1:0]    m_tnew_p1;
    logic [REG_AW-1:0] w_a3_p2;

    logic       stall_rs, stall_rt, stall_raw;
    logic [1:0] sel_d_rs, sel_d_rt, sel_e_rs, sel_e_rt, sel_m_rt;

    // Stall when an operand is needed before its producer in E or M delivers it
    always_comb begin
        stall_rs  = (D_rs != '0) &&
                    (((e_a3_p0 == D_rs) && (D_Tuse_rs < e_tnew_p0)) ||
                     ((m_a3_p1 == D_rs) && (D_Tuse_rs < m_tnew_p1)));
        stall_rt  = (D_rt != '0) &&
                    (((e_a3_p0 == D_rt) && (D_Tuse_rt < e_tnew_p0)) ||
                     ((m_a3_p1 == D_rt) && (D_Tuse_rt < m_tnew_p1)));
        stall_raw = stall_rs | stall_rt;
    end

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_d_rs (
        .reg_idx(D_rs), .e_a3(e_a3_p0), .m_a3(m_a3_p1), .w_a3(w_a3_p2),
        .e_rdy(e_tnew_p0 == '0), .m_rdy(m_tnew_p1 == '0), .sel(sel_d_rs)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_d_rt (
        .reg_idx(D_rt), .e_a3(e_a3_p0), .m_a3(m_a3_p1), .w_a3(w_a3_p2),
        .e_rdy(e_tnew_p0 == '0), .m_rdy(m_tnew_p1 == '0), .sel(sel_d_rt)
    );

    // E-stage reads see only older producers, so the E slot is masked off
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_e_rs (
        .reg_idx(e_rs_p0), .e_a3('0), .m_a3(m_a3_p1), .w_a3(w_a3_p2),
        .e_rdy(1'b0), .m_rdy(m_tnew_p1 == '0), .sel(sel_e_rs)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_e_rt (
        .reg_idx(e_rt_p0), .e_a3('0), .m_a3(m_a3_p1), .w_a3(w_a3_p2),
        .e_rdy(1'b0), .m_rdy(m_tnew_p1 == '0), .sel(sel_e_rt)
    );

    // Store data in M can only be bypassed from W
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_m_rt (
        .reg_idx(m_rt_p1), .e_a3('0), .m_a3('0), .w_a3(w_a3_p2),
        .e_rdy(1'b0), .m_rdy(1'b0), .sel(sel_m_rt)
    );

    // Force every control output quiet while reset is held
    always_comb begin
        stall    = reset & stall_raw;
        fwd_D_rs = reset ? sel_d_rs : FWD_NONE;
        fwd_D_rt = reset ? sel_d_rt : FWD_NONE;
        fwd_E_rs = reset ? sel_e_rs : FWD_NONE;
        fwd_E_rt = reset ? sel_e_rt : FWD_NONE;
        fwd_M_rt = reset & (sel_m_rt == FWD_W);
    end

    // Shadow pipeline advance: D -> E (bubble on stall), E -> M, M -> W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3_p0   <= '0;
            e_tnew_p0 <= '0;
            e_rs_p0   <= '0;
            e_rt_p0   <= '0;
            m_a3_p1   <= '0;
            m_tnew_p1 <= '0;
            m_rt_p1   <= '0;
            w_a3_p2   <= '0;
        end else begin
            // D -> E
            if (stall_raw) begin
                e_a3_p0   <= '0;
                e_tnew_p0 <= '0;
                e_rs_p0   <= '0;
                e_rt_p0   <= '0;
            end else begin
                e_a3_p0   <= D_A3;
                e_tnew_p0 <= sat_dec(D_Tnew);
                e_rs_p0   <= D_rs;
                e_rt_p0   <= D_rt;
            end
            // E -> M
            m_a3_p1   <= e_a3_p0;
            m_tnew_p1 <= sat_dec(e_tnew_p0);
            m_rt_p1   <= e_rt_p0;
            // M -> W
            w_a3_p2   <= m_a3_p1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Count stalled cycles; natural 32-bit wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall_raw)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction pairs from the test plan with
// hand-derived stall and forward-select expectations.
module tb_hazard_unit;

    import hazard_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       stall;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic       fwd_M_rt;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_AW(5), .T_W(2)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_Tnew(D_Tnew),
        .stall(stall),
        .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
        .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
        .fwd_M_rt(fwd_M_rt)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt, input logic [1:0] tnew);
        D_rs = rs; D_rt = rt; D_A3 = a3;
        D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt; D_Tnew = tnew;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 5'd0, TUSE_UNUSED, TUSE_UNUSED, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_d(5'd8, 5'd9, 5'd10, 2'd0, 2'd0, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_fwd_d", {fwd_D_rs, fwd_D_rt}, 4'b0);
        check("rst_fwd_em", {fwd_E_rs, fwd_E_rt, fwd_M_rt}, 5'b0);
`ifdef HAZARD_PERF_EN
        check("rst_cnt", stall_cnt, 32'd0);
`endif
        nop();
        reset = 1'b1;
        tick();

        // lw $t0 then add using $t0 in E: one stall, then W forward in E
        set_d(5'd29, 5'd8, 5'd8, 2'd1, TUSE_UNUSED, 2'd3);
        #1 check("lw_nostall", stall, 1'b0);
        tick();
        set_d(5'd8, 5'd9, 5'd11, 2'd1, 2'd1, 2'd2);
        #1 check("lwadd_stall1", stall, 1'b1);
        tick();
        #1 check("lwadd_stall_end", stall, 1'b0);
        check("lwadd_fwd_d_rs", fwd_D_rs, FWD_NONE);
        tick();
        nop();
        #1 check("lwadd_fwd_e_rs", fwd_E_rs, FWD_W);
        check("lwadd_fwd_e_rt", fwd_E_rt, FWD_NONE);
        flush();

        // add $t1 then beq on $t1 in D: one stall, then M forward in D
        set_d(5'd0, 5'd0, 5'd9, TUSE_UNUSED, TUSE_UNUSED, 2'd2);
        tick();
        set_d(5'd9, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
        #1 check("addbeq_stall1", stall, 1'b1);
        tick();
        #1 check("addbeq_stall_end", stall, 1'b0);
        check("addbeq_fwd_d_rs", fwd_D_rs, FWD_M);
        check("addbeq_fwd_d_rt", fwd_D_rt, FWD_NONE);
        tick();
        flush();

        // jal then jr $ra: no stall, forward from E
        set_d(5'd0, 5'd0, 5'd31, TUSE_UNUSED, TUSE_UNUSED, 2'd0);
        tick();
        set_d(5'd31, 5'd0, 5'd0, 2'd0, TUSE_UNUSED, 2'd0);
        #1 check("jaljr_stall", stall, 1'b0);
        check("jaljr_fwd_d_rs", fwd_D_rs, FWD_E);
        tick();
        flush();

        // lw to $zero then add reading $zero: nothing happens
        set_d(5'd29, 5'd0, 5'd0, 2'd1, TUSE_UNUSED, 2'd3);
        tick();
        set_d(5'd0, 5'd0, 5'd12, 2'd1, 2'd1, 2'd2);
        #1 check("zero_stall", stall, 1'b0);
        check("zero_fwd_d", {fwd_D_rs, fwd_D_rt}, 4'b0);
        tick();
        nop();
        #1 check("zero_fwd_e", {fwd_E_rs, fwd_E_rt}, 4'b0);
        flush();

        // lw $t2 then sw $t2: no stall, store data bypassed from W in M
        set_d(5'd29, 5'd10, 5'd10, 2'd1, TUSE_UNUSED, 2'd3);
        tick();
        set_d(5'd29, 5'd10, 5'd0, 2'd1, 2'd2, 2'd0);
        #1 check("lwsw_stall", stall, 1'b0);
        tick();
        nop();
        #1 check("lwsw_fwd_e_rt_notready", fwd_E_rt, FWD_NONE);
        check("lwsw_fwd_m_rt_early", fwd_M_rt, 1'b0);
        tick();
        #1 check("lwsw_fwd_m_rt", fwd_M_rt, 1'b1);
        flush();
        check("lwsw_fwd_m_rt_after", fwd_M_rt, 1'b0);
`ifdef HAZARD_PERF_EN
        check("cnt_two_stalls", stall_cnt, 32'd2);
`endif

        // Reset asserted in the middle of a stall cycle
        set_d(5'd0, 5'd0, 5'd8, TUSE_UNUSED, TUSE_UNUSED, 2'd3);
        tick();
        set_d(5'd8, 5'd0, 5'd11, 2'd1, TUSE_UNUSED, 2'd2);
        #1 check("rstmid_stall_before", stall, 1'b1);
        #2 reset = 1'b0;
        #1 check("rstmid_stall", stall, 1'b0);
        check("rstmid_fwd", {fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}, 9'b0);
`ifdef HAZARD_PERF_EN
        check("rstmid_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b1;
        #1 check("rstmid_cleared_stall", stall, 1'b0);
        tick();
        #1 check("rstmid_fwd_e_after", {fwd_E_rs, fwd_E_rt}, 4'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
